// File: rtl/eight_bit_down_counter.sv
// Loadable, pausable down-counter/timer with valid/ready load, start/pause and a one-cycle done pulse.
// Optional build macro: EIGHT_BIT_DOWN_COUNTER_AUTO_RELOAD_EN (periodic reload from the shadow register).
module eight_bit_down_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 64,
  parameter int unsigned FLOOR     = 5
) (
  input  logic             clck,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] FLOOR_V  = WIDTH'(FLOOR);
  localparam logic [WIDTH-1:0] FLOOR_P1 = WIDTH'(FLOOR + 1);
  localparam logic [WIDTH-1:0] RESET_V  = WIDTH'(RESET_VAL);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] load_val;
  logic             load_ok;
  logic             at_last;

  // Loads below the floor are clamped so the count can never start under it.
  assign load_val = (load_data > FLOOR_V) ? load_data : FLOOR_V;
  assign load_ok  = load_valid && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign at_last  = (count_q <= FLOOR_P1);

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= RESET_V;
      shadow_q <= RESET_V;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic: an accepted load always wins; start is then judged against the loaded value.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;

    if (load_ok) begin
      count_d  = load_val;
      shadow_d = load_val;
      state_d  = S_IDLE;
      if (start) begin
        if (load_val > FLOOR_V) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count_q > FLOOR_V) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN, S_HOLD: begin
          if (pause) begin
            state_d = S_HOLD;
          end else if (at_last) begin
            count_d = FLOOR_V;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
            state_d = S_RUN;
          end
        end
        S_DONE: begin
`ifdef EIGHT_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
          // A floor-valued shadow gives a one-cycle period: stay in DONE and pulse every cycle.
          if (start || !pause) begin
            if (shadow_q > FLOOR_V) begin
              count_d = shadow_q;
              state_d = S_RUN;
            end else begin
              done_d = 1'b1;
            end
          end
`else
          if (start) begin
            count_d = shadow_q;
            state_d = S_RUN;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d == S_RUN) || (state_d == S_HOLD);
    ready_d = !busy_d;
  end

  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_eight_bit_down_counter.sv
// Self-checking bench for eight_bit_down_counter: directed scenarios then random traffic vs a behavioural model.
module tb_eight_bit_down_counter;

  localparam int FLOOR     = 5;
  localparam int RESET_VAL = 64;

  logic       clck = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       start;
  logic       pause;
  logic [7:0] count;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;
  mode_t m_mode;
  int    m_count;
  int    m_shadow;
  bit    m_done;

  always #5 clck = ~clck;

  eight_bit_down_counter #(
    .WIDTH    (8),
    .RESET_VAL(RESET_VAL),
    .FLOOR    (FLOOR)
  ) dut (
    .clck      (clck),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .start     (start),
    .pause     (pause),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_count  = RESET_VAL;
    m_shadow = RESET_VAL;
    m_done   = 1'b0;
  endtask

  // Behavioural reference: what one clock edge does to the timer, from the block's rules.
  task automatic model_step(input bit lv, input int ld, input bit st, input bit ps);
    int v;
    m_done = 1'b0;
    if (lv && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      v = (ld > FLOOR) ? ld : FLOOR;
      m_count  = v;
      m_shadow = v;
      m_mode   = M_IDLE;
      if (st) begin
        if (v > FLOOR) m_mode = M_RUN;
        else begin m_mode = M_DONE; m_done = 1'b1; end
      end
    end else if (m_mode == M_IDLE) begin
      if (st) begin
        if (m_count > FLOOR) m_mode = M_RUN;
        else begin m_mode = M_DONE; m_done = 1'b1; end
      end
    end else if (m_mode == M_RUN || m_mode == M_HOLD) begin
      if (ps) m_mode = M_HOLD;
      else begin
        m_count = (m_count - 1 > FLOOR) ? m_count - 1 : FLOOR;
        m_mode  = M_RUN;
        if (m_count == FLOOR) begin m_mode = M_DONE; m_done = 1'b1; end
      end
    end else begin
`ifdef EIGHT_BIT_DOWN_COUNTER_AUTO_RELOAD_EN
      if (st || !ps) begin
        if (m_shadow > FLOOR) begin m_count = m_shadow; m_mode = M_RUN; end
        else m_done = 1'b1;
      end
`else
      if (st) begin m_count = m_shadow; m_mode = M_RUN; end
`endif
    end
  endtask

  task automatic compare_all(input string tag);
    bit m_busy;
    m_busy = (m_mode == M_RUN || m_mode == M_HOLD);
    check({tag, "_count"}, int'(count), m_count);
    check({tag, "_busy"}, int'(busy), int'(m_busy));
    check({tag, "_done"}, int'(done), int'(m_done));
    check({tag, "_ready"}, int'(load_ready), int'(!m_busy));
  endtask

  // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
  task automatic step(input string tag, input bit lv, input int ld, input bit st, input bit ps);
    load_valid = lv;
    load_data  = 8'(ld);
    start      = st;
    pause      = ps;
    model_step(lv, ld, st, ps);
    @(negedge clck);
    compare_all(tag);
  endtask

  initial begin
    int edges;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'd0;
    start      = 1'b0;
    pause      = 1'b0;
    model_reset();
    @(posedge clck);
    #2;
    compare_all("por");
    check("por_count_const", int'(count), 64);
    @(negedge clck);
    rst_n = 1'b1;

    // Load 10, start, count down to the floor.
    step("t2_load", 1'b1, 10, 1'b0, 1'b0);
    check("t2_loaded", int'(count), 10);
    step("t2_start", 1'b0, 0, 1'b1, 1'b0);
    check("t2_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) step("t2_run", 1'b0, 0, 1'b0, 1'b0);
    check("t2_floor", int'(count), 5);
    check("t2_done", int'(done), 1);
    step("t2_after", 1'b0, 0, 1'b0, 1'b0);
    check("t2_done_drop", int'(done), 0);
    check("t2_ready_back", int'(load_ready), 1);

    // Load 12, pause three cycles at 8: done arrives three edges late.
    step("t3_load", 1'b1, 12, 1'b0, 1'b0);
    step("t3_start", 1'b0, 0, 1'b1, 1'b0);
    edges = 0;
    for (int i = 0; i < 40 && m_count != 8; i++) begin
      step("t3_run", 1'b0, 0, 1'b0, 1'b0);
      edges++;
    end
    for (int i = 0; i < 3; i++) begin
      step("t3_pause", 1'b0, 0, 1'b0, 1'b1);
      edges++;
      check("t3_hold8", int'(count), 8);
    end
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      step("t3_resume", 1'b0, 0, 1'b0, 1'b0);
      edges++;
    end
    check("t3_latency", edges, 12 - FLOOR + 3);

    // Load below floor clamps; start goes straight to DONE; second start reloads the floor.
    step("t4_load", 1'b1, 3, 1'b0, 1'b0);
    check("t4_clamp", int'(count), 5);
    step("t4_start", 1'b0, 0, 1'b1, 1'b0);
    check("t4_done", int'(done), 1);
    step("t4_idle", 1'b0, 0, 1'b0, 1'b0);
    step("t4_restart", 1'b0, 0, 1'b1, 1'b0);
    check("t4_restart_count", int'(count), 5);
    for (int i = 0; i < 3; i++) step("t4_run", 1'b0, 0, 1'b0, 1'b0);

    // Load during RUN is refused; the shadow keeps the last accepted value.
    step("t5_load", 1'b1, 10, 1'b0, 1'b0);
    step("t5_start", 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_count != 7; i++) step("t5_run", 1'b0, 0, 1'b0, 1'b0);
    check("t5_ready_low", int'(load_ready), 0);
    step("t5_badload", 1'b1, 20, 1'b0, 1'b0);
    check("t5_ignored", int'(count), 6);
    for (int i = 0; i < 4; i++) step("t5_run", 1'b0, 0, 1'b0, 1'b0);
    step("t5_reload", 1'b0, 0, 1'b1, 1'b0);
    check("t5_shadow", int'(count), 10);
    for (int i = 0; i < 8; i++) step("t5_tail", 1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at 30, observed before the next rising edge.
    step("t1_load", 1'b1, 40, 1'b0, 1'b0);
    step("t1_start", 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_count != 30; i++) step("t1_run", 1'b0, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_count", int'(count), 64);
    check("t1_rst_busy", int'(busy), 0);
    check("t1_rst_ready", int'(load_ready), 1);
    check("t1_rst_done", int'(done), 0);
    model_reset();
    @(negedge clck);
    rst_n = 1'b1;
    compare_all("t1_post");

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step("rnd", ($urandom_range(0, 5) == 0), int'($urandom_range(0, 30)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
